// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM capture path: FSM state encoding and the
// timeout constant derived from the counter width.
package pwm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_MEASURE = 2'd2,
    ST_STUCK   = 2'd3
  } pwm_state_e;

  // Longest measurable period in clocks; reaching it without a rise means the input is stuck.
  function automatic int timeout_count(input int width);
    return 1 << width;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer for inputs asynchronous to clk.
// Both flops clear on the asynchronous active-low reset.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pwm_capture.sv
// Recovers high time and period of an incoming PWM waveform, encoded like the
// generator's duty/max_value, and flags an input that stops toggling.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | disabled; counters cleared, outputs hold last values
// ARM     | waiting for the first rise; the partial window is discarded
// MEASURE | counting a full period; each rise publishes a measurement
// STUCK   | no rise within 2^bit_width clocks; waiting for any edge
module pwm_capture #(
  parameter int bit_width = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 pwm_in,
  output logic [bit_width-1:0] duty_out,
  output logic [bit_width-1:0] period_out,
  output logic                 valid,
  output logic                 stuck,
  output logic                 stuck_level
);
  import pwm_pkg::*;

  localparam logic [bit_width:0]   TIMEOUT_CNT = (bit_width+1)'(timeout_count(bit_width));
  localparam logic [bit_width:0]   PER_ONE     = (bit_width+1)'(1);
  localparam logic [bit_width-1:0] HI_ONE      = bit_width'(1);

  logic s;
  logic s_d_q;
  logic rise;
  logic fall;
  logic timeout;

  pwm_state_e state_q, state_d;
  logic [bit_width:0]   per_cnt_q, per_cnt_d;
  logic [bit_width-1:0] hi_cnt_q, hi_cnt_d;
  logic [bit_width-1:0] duty_q, duty_d;
  logic [bit_width-1:0] period_q, period_d;
  logic                 valid_q, valid_d;
  logic                 stuck_q, stuck_d;
  logic                 stuck_level_q, stuck_level_d;

  logic [bit_width:0]   per_inc;
  logic [bit_width-1:0] hi_inc;
  logic [bit_width-1:0] period_meas;

  sync_2ff u_sync_pwm (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (pwm_in),
    .q_o   (s)
  );

  assign rise    = s & ~s_d_q;
  assign fall    = ~s & s_d_q;
  assign timeout = (per_cnt_q == TIMEOUT_CNT) && !rise;

  // per_cnt saturates so a dead input keeps timeout asserted instead of wrapping.
  assign per_inc     = (per_cnt_q == TIMEOUT_CNT) ? per_cnt_q : per_cnt_q + PER_ONE;
  assign hi_inc      = hi_cnt_q + {{(bit_width-1){1'b0}}, s};
  // Low bits of 2^bit_width are zero, so the truncated subtract still yields all ones.
  assign period_meas = per_cnt_q[bit_width-1:0] - HI_ONE;

  always_comb begin
    state_d       = state_q;
    per_cnt_d     = per_inc;
    hi_cnt_d      = hi_inc;
    duty_d        = duty_q;
    period_d      = period_q;
    valid_d       = 1'b0;
    stuck_d       = stuck_q;
    stuck_level_d = stuck_level_q;

    if (!enable) begin
      state_d   = ST_IDLE;
      per_cnt_d = '0;
      hi_cnt_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          per_cnt_d = '0;
          hi_cnt_d  = '0;
          state_d   = ST_ARM;
        end
        ST_ARM, ST_MEASURE: begin
          if (rise) begin
            per_cnt_d = PER_ONE;
            hi_cnt_d  = HI_ONE;
            state_d   = ST_MEASURE;
            if (state_q == ST_MEASURE) begin
              duty_d   = hi_cnt_q;
              period_d = period_meas;
              valid_d  = 1'b1;
              stuck_d  = 1'b0;
            end
          end else if (timeout) begin
            state_d       = ST_STUCK;
            stuck_d       = 1'b1;
            stuck_level_d = s;
            duty_d        = s ? '1 : '0;
            period_d      = '1;
            valid_d       = 1'b1;
          end
        end
        ST_STUCK: begin
          // stuck stays set here; only a full measurement clears it.
          if (rise) begin
            per_cnt_d = PER_ONE;
            hi_cnt_d  = HI_ONE;
            state_d   = ST_MEASURE;
          end else if (fall) begin
            per_cnt_d = '0;
            state_d   = ST_ARM;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_d_q         <= 1'b0;
      state_q       <= ST_IDLE;
      per_cnt_q     <= '0;
      hi_cnt_q      <= '0;
      duty_q        <= '0;
      period_q      <= '0;
      valid_q       <= 1'b0;
      stuck_q       <= 1'b0;
      stuck_level_q <= 1'b0;
    end else begin
      s_d_q         <= s;
      state_q       <= state_d;
      per_cnt_q     <= per_cnt_d;
      hi_cnt_q      <= hi_cnt_d;
      duty_q        <= duty_d;
      period_q      <= period_d;
      valid_q       <= valid_d;
      stuck_q       <= stuck_d;
      stuck_level_q <= stuck_level_d;
    end
  end

  assign duty_out    = duty_q;
  assign period_out  = period_q;
  assign valid       = valid_q;
  assign stuck       = stuck_q;
  assign stuck_level = stuck_level_q;

endmodule

// File: doc/pwm_capture.md
Name: pwm_capture

Overview:
- Receive-side counterpart of the team's PWM generator. It measures an incoming PWM waveform and recovers its high time and period.
- Output encoding matches the generator's inputs:
  - duty_out equals the generator's duty.
  - period_out equals the generator's max_value.
  - Looping the generator output into this block therefore reproduces the generator settings.
- Sits on the loop-back/feedback path and feeds the control logic that compares commanded versus observed PWM.

Parameters:
- bit_width, 8: width of duty_out/period_out. The maximum measurable period is 2^bit_width clocks.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- enable  input  1  measurement enable. Low forces IDLE.
- pwm_in  input  1  PWM waveform, possibly asynchronous to clk
- duty_out  output  bit_width  high cycles in last full period
- period_out  output  bit_width  last full period length minus 1
- valid  output  1  one-cycle pulse when duty_out/period_out update
- stuck  output  1  no rising edge seen within 2^bit_width clocks
- stuck_level  output  1  synchronized level of pwm_in when stuck was set

Behaviour:
- Reset (asynchronous, rst_n low): all outputs are 0, state is IDLE, counters are 0, sync flops are 0. Reset deasserted mid-operation restarts from IDLE. The next valid requires two rising edges.
- Input conditioning:
  - pwm_in passes through a 2-flop synchronizer to give s.
  - s_d is s delayed one cycle.
  - rise = s & ~s_d; fall = ~s & s_d.
  - No glitch filtering.
- Counters:
  - per_cnt is bit_width+1 bits.
  - hi_cnt is bit_width bits.
  - On a rise cycle: per_cnt <= 1, hi_cnt <= 1.
  - Otherwise: per_cnt <= per_cnt + 1 (saturating at 2^bit_width), hi_cnt <= hi_cnt + s.
- Timeout: per_cnt == 2^bit_width and no rise in the current cycle.
- States:
  - IDLE: counters held at 0, outputs hold their last values. Goes to ARM when enable = 1.
  - ARM: the partial window is discarded.
    - On rise: initialise counters, go to MEASURE, no valid.
    - On timeout: go to STUCK.
  - MEASURE:
    - On rise: duty_out <= hi_cnt, period_out <= per_cnt - 1 (truncated to bit_width), valid <= 1, stuck <= 0, counters re-initialised. Stays in MEASURE.
    - On timeout: go to STUCK.
  - STUCK:
    - On entry: stuck <= 1, stuck_level <= s, duty_out <= (s ? all ones : 0), period_out <= all ones, valid pulses once.
    - On rise: initialise counters, go to MEASURE. stuck stays 1 until the next valid measurement.
    - On fall: per_cnt <= 0, go to ARM.
- enable = 0 in any state: go to IDLE next cycle. An in-progress window is abandoned and no valid is issued.
- Latency: valid, duty_out and period_out are registered outputs. They change 1 cycle after rise is asserted, which is 3 clocks after pwm_in is first sampled high.
- Width rules:
  - hi_cnt is at most per_cnt - 1, so it never overflows.
  - period_out = per_cnt - 1 always fits in bit_width bits.
- Simultaneous events:
  - rise takes priority over timeout.
  - enable = 0 takes priority over rise and timeout.
- valid is never asserted for two consecutive cycles. The minimum spacing between valid pulses is 2 clocks.

Decomposition:
- Shared package pwm_pkg holds:
  - the state encoding constants (IDLE, ARM, MEASURE, STUCK, 2 bits);
  - a function for the timeout constant 2^bit_width.
- One sub-module: sync_2ff, the single-bit 2-flop synchronizer with asynchronous active-low reset. It is reusable by other inputs in the design.
- Edge detection and the FSM stay in pwm_capture.

Test Plan:
1. Generator duty=64, max_value=255, looped to pwm_in, enable=1.
   - No valid before the 2nd rising edge.
   - Then valid every 256 clocks with duty_out=64, period_out=255, stuck=0.
2. Generator duty=3, max_value=9.
   - valid every 10 clocks with duty_out=3, period_out=9.
   - Then duty=1, max_value=1: valid every 2 clocks with duty_out=1, period_out=1.
3. Generator duty=0 (constant low).
   - stuck=1, stuck_level=0, duty_out=0, period_out=255.
   - Exactly one valid, occurring 256 clocks after the last rise (or after entering ARM).
   - Then duty=128: stuck clears with the first full-window valid, duty_out=128.
4. Generator duty=255, max_value=254 (constant high).
   - stuck=1, stuck_level=1, duty_out=255, period_out=255.
   - A later low pulse (fall) returns the block to ARM with no valid.
5. Change duty 64→128 mid-stream.
   - At most one transitional valid.
   - All subsequent valid pulses report 128/255.
   - Deassert enable mid-period: no valid while low; outputs hold.
   - Re-enable: first valid after 2 rises.
6. Assert rst_n low asynchronously between clock edges during MEASURE.
   - All outputs are 0 immediately.
   - After release, behaviour matches scenario 1 from the start.
